// File: rtl/avg_frame_sequencer.sv
// avg_frame_sequencer: block averager for a signed sample stream.
// Discards a configurable number of settle samples after start, then
// sums frames of exactly 2^n valid samples and emits sum and floor average.
// Frames run once or back-to-back (gap-free) until stop.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, stop       software control (start sampled only when idle)
//   continuous        repeat frames until stop (latched on start)
//   log2_samples_cfg  frame exponent n, clamped to max_log2_samples
//   settle_cfg        valid samples to discard after start
//   in_data/in_valid  signed input sample and qualifier
//   sum_out/avg_out   registered frame sum and average
//   out_valid         one-cycle strobe marking a new result
//   busy              high while not idle
//   frame_count       frames emitted since last start (wraps)
module avg_frame_sequencer #(
    parameter int dat_in_bits      = 16,
    parameter int max_log2_samples = 8,
    parameter int settle_bits      = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         stop,
    input  logic                                         continuous,
    input  logic [3:0]                                   log2_samples_cfg,
    input  logic [settle_bits-1:0]                       settle_cfg,
    input  logic signed [dat_in_bits-1:0]                in_data,
    input  logic                                         in_valid,
    output logic signed [dat_in_bits+max_log2_samples-1:0] sum_out,
    output logic signed [dat_in_bits-1:0]                avg_out,
    output logic                                         out_valid,
    output logic                                         busy,
    output logic [15:0]                                  frame_count
);

    localparam int AW = dat_in_bits + max_log2_samples;
    localparam int CW = max_log2_samples + 1;
    localparam int NW = (max_log2_samples < 1) ? 1 : $clog2(max_log2_samples + 1);
    localparam logic [3:0] NMAX = 4'(max_log2_samples);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM
    } state_t;

    state_t                  state_q;
    logic                    cont_q;
    logic [NW-1:0]           n_q;
    logic [settle_bits-1:0]  settle_q;
    logic [settle_bits-1:0]  settle_cnt_q;
    logic [CW-1:0]           cnt_q;
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    sum_q;
    logic signed [dat_in_bits-1:0] avg_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic [15:0]             frame_count_q;
    logic                    stop_pending_q;

    logic [NW-1:0]           n_clamp;
    logic signed [AW-1:0]    sample_ext;
    logic signed [AW-1:0]    acc_sum;
    logic signed [AW-1:0]    avg_full;
    logic [CW-1:0]           ones;
    logic [CW-1:0]           last_idx;
    logic                    frame_last;
    logic                    keep_running;

    always_comb begin
        n_clamp = NW'(log2_samples_cfg);
        if (log2_samples_cfg > NMAX) begin
            n_clamp = NW'(NMAX);
        end
    end

    assign sample_ext = $signed({{max_log2_samples{in_data[dat_in_bits-1]}}, in_data});
    assign acc_sum    = acc_q + sample_ext;
    // Arithmetic shift on a signed operand gives floor toward -inf.
    assign avg_full   = acc_sum >>> n_q;
    assign ones       = '1;
    assign last_idx   = ~(ones << n_q);
    assign frame_last = (cnt_q == last_idx);
    // A stop arriving on the completing cycle also ends the run.
    assign keep_running = cont_q && !stop_pending_q && !stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cont_q         <= 1'b0;
            n_q            <= '0;
            settle_q       <= '0;
            settle_cnt_q   <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            sum_q          <= '0;
            avg_q          <= '0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_count_q  <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cont_q         <= continuous;
                        n_q            <= n_clamp;
                        settle_q       <= settle_cfg;
                        settle_cnt_q   <= '0;
                        cnt_q          <= '0;
                        acc_q          <= '0;
                        frame_count_q  <= '0;
                        stop_pending_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= (settle_cfg != '0) ? SETTLE : ACCUM;
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (in_valid) begin
                        if (settle_cnt_q == settle_q - settle_bits'(1)) begin
                            settle_cnt_q <= '0;
                            state_q      <= ACCUM;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + settle_bits'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (stop) begin
                        stop_pending_q <= 1'b1;
                    end
                    if (in_valid) begin
                        if (frame_last) begin
                            sum_q         <= acc_sum;
                            avg_q         <= avg_full[dat_in_bits-1:0];
                            out_valid_q   <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                            // Reload now so the next cycle's sample opens the next frame.
                            acc_q         <= '0;
                            cnt_q         <= '0;
                            if (!keep_running) begin
                                state_q        <= IDLE;
                                busy_q         <= 1'b0;
                                stop_pending_q <= 1'b0;
                            end
                        end else begin
                            acc_q <= acc_sum;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sum_out     = sum_q;
    assign avg_out     = avg_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_avg_frame_sequencer.sv
// tb_avg_frame_sequencer: directed table-driven bench for avg_frame_sequencer.
// Table rows cover basic frames; hand sequences cover multi-cycle corners.
module tb_avg_frame_sequencer;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [3:0]         log2_samples_cfg;
    logic [7:0]         settle_cfg;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic signed [23:0] sum_out;
    logic signed [15:0] avg_out;
    logic               out_valid;
    logic               busy;
    logic [15:0]        frame_count;

    int checks;
    int errors;

    avg_frame_sequencer #(
        .dat_in_bits(16),
        .max_log2_samples(8),
        .settle_bits(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .continuous(continuous),
        .log2_samples_cfg(log2_samples_cfg),
        .settle_cfg(settle_cfg),
        .in_data(in_data),
        .in_valid(in_valid),
        .sum_out(sum_out),
        .avg_out(avg_out),
        .out_valid(out_valid),
        .busy(busy),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               start;
        logic               stop;
        logic               cont;
        logic [3:0]         n;
        logic [7:0]         settle;
        logic               v;
        logic signed [15:0] d;
        logic               e_ov;
        logic               e_busy;
        logic signed [23:0] e_sum;
        logic signed [15:0] e_avg;
        logic [15:0]        e_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int st, int sp, int co, int n, int se,
                                int v, int d, int ov, int bz, int s,
                                int a, int fc);
        vec_t r;
        r.start  = st[0];
        r.stop   = sp[0];
        r.cont   = co[0];
        r.n      = n[3:0];
        r.settle = se[7:0];
        r.v      = v[0];
        r.d      = d[15:0];
        r.e_ov   = ov[0];
        r.e_busy = bz[0];
        r.e_sum  = s[23:0];
        r.e_avg  = a[15:0];
        r.e_fc   = fc[15:0];
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(int st, int sp, int co, int n, int se, int v, int d);
        start            = st[0];
        stop             = sp[0];
        continuous       = co[0];
        log2_samples_cfg = n[3:0];
        settle_cfg       = se[7:0];
        in_valid         = v[0];
        in_data          = d[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, int ov, int bz, int s, int a, int fc);
        chk({tag, ".out_valid"}, out_valid, ov);
        chk({tag, ".busy"}, busy, bz);
        chk({tag, ".sum_out"}, sum_out, s);
        chk({tag, ".avg_out"}, avg_out, a);
        chk({tag, ".frame_count"}, frame_count, fc);
    endtask

    task automatic extreme(string tag, int ncfg, int val, int es, int ea);
        int ns;
        int last_ov;
        ns = 0;
        last_ov = 0;
        drive(1, 0, 0, ncfg, 0, 0, 0);
        tick();
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 0, 0, 0, 1, val);
            tick();
            if (out_valid) ns++;
            if (i == 255) last_ov = int'(out_valid);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk({tag, ".strobes"}, ns, 1);
        chk({tag, ".last_strobe"}, last_ov, 1);
        chk({tag, ".sum"}, sum_out, es);
        chk({tag, ".avg"}, avg_out, ea);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        int ns;
        checks = 0;
        errors = 0;

        // Basic single frame, n=2.
        tbl.push_back(mk(1,0,0,2,0, 0,0,   0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,4,   0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,8,   0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,-4,  0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,12,  1,0,20,5,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,   0,0,20,5,1));
        // Settle of 3 with gaps, n=1, floor average.
        tbl.push_back(mk(1,0,0,1,3, 0,0,   0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,100, 0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 0,55,  0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,100, 0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 0,55,  0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,100, 0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 0,55,  0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,7,   0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 0,55,  0,1,20,5,0));
        tbl.push_back(mk(0,0,0,0,0, 1,-8,  1,0,-1,-1,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,   0,0,-1,-1,1));
        // n=0 continuous, start+stop together, later stop ends run.
        tbl.push_back(mk(1,1,1,0,0, 0,0,   0,1,-1,-1,0));
        tbl.push_back(mk(0,0,0,0,0, 1,5,   1,1,5,5,1));
        tbl.push_back(mk(0,0,0,0,0, 1,-3,  1,1,-3,-3,2));
        tbl.push_back(mk(0,0,0,0,0, 1,7,   1,1,7,7,3));
        tbl.push_back(mk(0,1,0,0,0, 0,0,   0,1,7,7,3));
        tbl.push_back(mk(0,0,0,0,0, 1,9,   1,0,9,9,4));
        tbl.push_back(mk(0,0,0,0,0, 0,0,   0,0,9,9,4));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(int'(tbl[i].start), int'(tbl[i].stop), int'(tbl[i].cont),
                  int'(tbl[i].n), int'(tbl[i].settle), int'(tbl[i].v),
                  int'(tbl[i].d));
            tick();
            chk_all($sformatf("row%0d", i), int'(tbl[i].e_ov),
                    int'(tbl[i].e_busy), int'(tbl[i].e_sum),
                    int'(tbl[i].e_avg), int'(tbl[i].e_fc));
        end

        // Continuous ramp, n=3; start while busy ignored; stop mid frame 5.
        drive(1, 0, 1, 3, 0, 0, 0);
        tick();
        ns = 0;
        for (int i = 0; i < 40; i++) begin
            drive(i == 10 ? 1 : 0, i == 35 ? 1 : 0, 0, 0, 0, 1, i);
            tick();
            chk($sformatf("ramp.busy%0d", i), busy, (i < 39) ? 1 : 0);
            if (out_valid) begin
                chk("ramp.idx", i, 8 * ns + 7);
                chk("ramp.sum", sum_out, 64 * ns + 28);
                chk("ramp.avg", avg_out, 8 * ns + 3);
                chk("ramp.fc", frame_count, ns + 1);
                ns++;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ramp.strobes", ns, 5);

        extreme("neg_clamp", 12, -32768, -8388608, -32768);
        extreme("pos", 8, 32767, 8388352, 32767);

        // Stop during settle returns to idle with no strobe.
        drive(1, 0, 0, 1, 5, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        tick();
        drive(0, 1, 0, 0, 0, 1, 1);
        tick();
        chk("settle_stop.busy", busy, 0);
        chk("settle_stop.ov", out_valid, 0);
        ns = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1, 2);
            tick();
            if (out_valid) ns++;
        end
        chk("settle_stop.strobes", ns, 0);
        chk("settle_stop.fc", frame_count, 0);

        // Reset mid-accumulation clears everything, no strobe.
        drive(1, 0, 1, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_mid", 0, 0, 0, 0, 0);
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) ns++;
        end
        chk("rst_mid.strobes", ns, 0);
        chk("rst_mid.busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
